// File: rtl/hwpe_stream_tcdm_reorder_ctrl.sv
// ----------------------------------------------------------------------------
// hwpe_stream_tcdm_reorder_ctrl
//
// Generates the rotation index used by an NB_CHAN-channel TCDM reorder stage.
// Rotating the channel-to-bank mapping spreads bank pressure evenly across the
// downstream TCDM channels. The rotation advances after a programmable number
// of eligible cycles. While any downstream request is still waiting for its
// grant, the mapping is never changed, so a held request is not re-routed to a
// different bank in the middle of its handshake.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset (clears everything)
//   clear_i      synchronous soft clear (like reset, but keeps stall_cnt_o)
//   enable_i     rotation enable; when low, order_o is frozen
//   mode_i       0: count cycles with any req_i high, 1: count every enabled cycle
//   period_i     eligible cycles per rotation (0 behaves as 1)
//   req_i        downstream TCDM request, one bit per channel
//   gnt_i        downstream TCDM grant, one bit per channel
//   order_o      rotation index, 0..NB_CHAN-1
//   rotate_o     one-cycle pulse in the first cycle a new order_o is visible
//   holding_o    high while a due rotation is blocked by a pending request
//   stall_cnt_o  saturating count of cycles spent blocked in HOLD
// ----------------------------------------------------------------------------
module hwpe_stream_tcdm_reorder_ctrl #(
    parameter  int unsigned NB_CHAN  = 4,
    parameter  int unsigned PERIOD_W = 8,
    parameter  int unsigned CNT_W    = 16,
    localparam int unsigned ORDER_W  = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                enable_i,
    input  logic                mode_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [NB_CHAN-1:0]  req_i,
    input  logic [NB_CHAN-1:0]  gnt_i,
    output logic [ORDER_W-1:0]  order_o,
    output logic                rotate_o,
    output logic                holding_o,
    output logic [CNT_W-1:0]    stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } state_t;

    state_t              state;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] eff_period;
    logic                pending;
    logic                eligible;
    logic                due;
    logic [ORDER_W-1:0]  next_order;

    always_comb begin
        // A grant on a channel without a request contributes nothing here.
        pending    = |(req_i & ~gnt_i);
        eligible   = enable_i & (mode_i | (|req_i));
        eff_period = (period_i == '0) ? PERIOD_W'(1) : period_i;
        // >= so that shrinking period_i below the running count fires on the
        // next eligible cycle instead of waiting for the counter to wrap.
        due        = (cnt >= (eff_period - PERIOD_W'(1)));
        // Explicit wrap keeps non-power-of-two channel counts in range.
        next_order = (order_o == ORDER_W'(NB_CHAN - 1)) ? '0 : order_o + ORDER_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            order_o     <= '0;
            rotate_o    <= 1'b0;
            holding_o   <= 1'b0;
            stall_cnt_o <= '0;
        end else if (clear_i) begin
            state     <= IDLE;
            cnt       <= '0;
            order_o   <= '0;
            rotate_o  <= 1'b0;
            holding_o <= 1'b0;
        end else begin
            rotate_o <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (enable_i) begin
                        state <= COUNT;
                    end
                end

                COUNT: begin
                    if (!enable_i) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (eligible) begin
                        if (due) begin
                            cnt <= '0;
                            if (pending) begin
                                state     <= HOLD;
                                holding_o <= 1'b1;
                            end else begin
                                order_o  <= next_order;
                                rotate_o <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + PERIOD_W'(1);
                        end
                    end
                end

                HOLD: begin
                    if (!enable_i) begin
                        // The blocked rotation is dropped, not deferred.
                        state     <= IDLE;
                        holding_o <= 1'b0;
                    end else if (pending) begin
                        if (stall_cnt_o != '1) begin
                            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
                        end
                    end else begin
                        state     <= COUNT;
                        holding_o <= 1'b0;
                        order_o   <= next_order;
                        rotate_o  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    holding_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hwpe_stream_tcdm_reorder_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for hwpe_stream_tcdm_reorder_ctrl.
// Three instances share one stimulus stream: 4 channels / 16-bit stall count,
// 3 channels / 16-bit stall count, and 4 channels / 4-bit stall count.
// A behavioural model pushes the expected outputs of each instance into a
// scoreboard queue as stimulus is driven; entries are popped and compared
// after the clock edge. Directed checks add fixed expectations per scenario.
// ----------------------------------------------------------------------------
module tb_hwpe_stream_tcdm_reorder_ctrl;

    logic       clk = 1'b0;
    logic       rst, clr, en, mode;
    logic [7:0] period;
    logic [3:0] req, gnt;

    logic [1:0]  a_order, b_order, c_order;
    logic        a_rot, b_rot, c_rot;
    logic        a_hold, b_hold, c_hold;
    logic [15:0] a_stall, b_stall;
    logic [3:0]  c_stall;

    always #5 clk = ~clk;

    hwpe_stream_tcdm_reorder_ctrl #(.NB_CHAN(4), .PERIOD_W(8), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .enable_i(en), .mode_i(mode),
        .period_i(period), .req_i(req), .gnt_i(gnt),
        .order_o(a_order), .rotate_o(a_rot), .holding_o(a_hold), .stall_cnt_o(a_stall)
    );

    hwpe_stream_tcdm_reorder_ctrl #(.NB_CHAN(3), .PERIOD_W(8), .CNT_W(16)) u_b (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .enable_i(en), .mode_i(mode),
        .period_i(period), .req_i(req[2:0]), .gnt_i(gnt[2:0]),
        .order_o(b_order), .rotate_o(b_rot), .holding_o(b_hold), .stall_cnt_o(b_stall)
    );

    hwpe_stream_tcdm_reorder_ctrl #(.NB_CHAN(4), .PERIOD_W(8), .CNT_W(4)) u_c (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .enable_i(en), .mode_i(mode),
        .period_i(period), .req_i(req), .gnt_i(gnt),
        .order_o(c_order), .rotate_o(c_rot), .holding_o(c_hold), .stall_cnt_o(c_stall)
    );

    typedef struct {
        int order;
        int rot;
        int hold;
        int stall;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Model configuration and state per instance (0 = u_a, 1 = u_b, 2 = u_c).
    localparam int S_IDLE = 0, S_COUNT = 1, S_HOLD = 2;
    int       cfg_nb[3]   = '{4, 3, 4};
    int       cfg_smax[3] = '{65535, 65535, 15};
    bit [3:0] cfg_mask[3] = '{4'b1111, 4'b0111, 4'b1111};
    int m_state[3], m_cnt[3], m_order[3], m_rot[3], m_hold[3], m_stall[3];

    int rot_a, hold_a, bad_b;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_step(input int k);
        int effp;
        bit pend, elig;
        effp = (period == 0) ? 1 : int'(period);
        pend = |(req & ~gnt & cfg_mask[k]);
        elig = en && (mode || (|(req & cfg_mask[k])));
        if (rst) begin
            m_state[k] = S_IDLE; m_cnt[k] = 0; m_order[k] = 0;
            m_rot[k] = 0; m_hold[k] = 0; m_stall[k] = 0;
        end else if (clr) begin
            m_state[k] = S_IDLE; m_cnt[k] = 0; m_order[k] = 0;
            m_rot[k] = 0; m_hold[k] = 0;
        end else begin
            m_rot[k] = 0;
            if (m_state[k] == S_IDLE) begin
                m_cnt[k] = 0;
                if (en) m_state[k] = S_COUNT;
            end else if (m_state[k] == S_COUNT) begin
                if (!en) begin
                    m_state[k] = S_IDLE;
                    m_cnt[k] = 0;
                end else if (elig && m_cnt[k] >= effp - 1) begin
                    m_cnt[k] = 0;
                    if (pend) begin
                        m_state[k] = S_HOLD;
                        m_hold[k] = 1;
                    end else begin
                        m_order[k] = (m_order[k] + 1) % cfg_nb[k];
                        m_rot[k] = 1;
                    end
                end else if (elig) begin
                    m_cnt[k]++;
                end
            end else begin
                if (!en) begin
                    m_state[k] = S_IDLE;
                    m_hold[k] = 0;
                end else if (pend) begin
                    if (m_stall[k] < cfg_smax[k]) m_stall[k]++;
                end else begin
                    m_state[k] = S_COUNT;
                    m_hold[k] = 0;
                    m_order[k] = (m_order[k] + 1) % cfg_nb[k];
                    m_rot[k] = 1;
                end
            end
        end
        q.push_back('{m_order[k], m_rot[k], m_hold[k], m_stall[k]});
    endtask

    task automatic compare_one(input int k, input int o, input int r, input int h, input int s);
        exp_t e;
        if (q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = q.pop_front();
            chk($sformatf("order[%0d]", k), o, e.order);
            chk($sformatf("rotate[%0d]", k), r, e.rot);
            chk($sformatf("holding[%0d]", k), h, e.hold);
            chk($sformatf("stall[%0d]", k), s, e.stall);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 3; k++) model_step(k);
            @(posedge clk);
            #1;
            compare_one(0, int'(a_order), int'(a_rot), int'(a_hold), int'(a_stall));
            compare_one(1, int'(b_order), int'(b_rot), int'(b_hold), int'(b_stall));
            compare_one(2, int'(c_order), int'(c_rot), int'(c_hold), int'(c_stall));
            rot_a  += int'(a_rot);
            hold_a += int'(a_hold);
            if (b_order >= 2'd3) bad_b++;
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; en = 1'b0; mode = 1'b0;
        period = 8'd0; req = '0; gnt = '0;
        rot_a = 0; hold_a = 0; bad_b = 0;
        for (int k = 0; k < 3; k++) begin
            m_state[k] = S_IDLE; m_cnt[k] = 0; m_order[k] = 0;
            m_rot[k] = 0; m_hold[k] = 0; m_stall[k] = 0;
        end
        #2;
        cyc(2);
        chk("reset_order", a_order, 0);
        chk("reset_stall", a_stall, 0);
        chk("reset_hold", a_hold, 0);

        // Mode 0, period 3, request always granted: one IDLE->COUNT cycle,
        // then a rotation every 3 eligible cycles -> 4 rotations in 13 cycles.
        rst = 1'b0; en = 1'b1; mode = 1'b0; period = 8'd3;
        req = 4'b0001; gnt = 4'b0001;
        rot_a = 0; hold_a = 0;
        cyc(13);
        chk("s1_rotations", rot_a, 4);
        chk("s1_order_wrap", a_order, 0);
        chk("s1_no_hold", hold_a, 0);
        chk("s1_order_nb3", b_order, 1);

        // Period 2: one eligible cycle, then a request left ungranted for 5
        // cycles. The first of those decides and enters HOLD; the remaining 4
        // stall. The granting cycle rotates.
        period = 8'd2; rot_a = 0; hold_a = 0;
        cyc(1);
        req = 4'b0100; gnt = 4'b0000;
        cyc(5);
        chk("s2_order_held", a_order, 0);
        chk("s2_no_rot_in_hold", rot_a, 0);
        gnt = 4'b0100;
        cyc(1);
        chk("s2_hold_cycles", hold_a, 5);
        chk("s2_stall", a_stall, 4);
        chk("s2_order_after", a_order, 1);
        chk("s2_rot_pulse", a_rot, 1);

        // Mode 0 with no requests: nothing is eligible.
        req = '0; gnt = '0; mode = 1'b0; rot_a = 0;
        cyc(10);
        chk("s3_idle_rot", rot_a, 0);
        chk("s3_idle_order", a_order, 1);
        // Mode 1 with period 0: rotate every cycle; stray grants are ignored.
        mode = 1'b1; period = 8'd0; gnt = 4'b1010;
        cyc(6);
        chk("s3_mode1_rot", rot_a, 6);
        chk("s3_mode1_order", a_order, 3);
        chk("s3_nb3_range", bad_b, 0);

        // Build up stall count 7, then soft clear.
        period = 8'd1; req = 4'b0001; gnt = 4'b0000;
        cyc(4);
        chk("s5_stall_pre", a_stall, 7);
        chk("s5_hold_pre", a_hold, 1);
        clr = 1'b1;
        cyc(1);
        chk("s5_clr_order", a_order, 0);
        chk("s5_clr_hold", a_hold, 0);
        chk("s5_clr_stall_kept", a_stall, 7);
        chk("s5_clr_rot", a_rot, 0);
        clr = 1'b0; req = '0;
        cyc(2);
        chk("s5_resume_order", a_order, 1);
        rst = 1'b1;
        cyc(1);
        chk("s5_rst_stall", a_stall, 0);
        chk("s5_rst_order", a_order, 0);
        rst = 1'b0;

        // Long HOLD for saturation, then disable mid-HOLD.
        req = 4'b0001; gnt = 4'b0000; en = 1'b1; mode = 1'b1; period = 8'd1;
        cyc(22);
        chk("s6_stall_wide", a_stall, 20);
        chk("s6_stall_sat", c_stall, 15);
        chk("s6_holding", c_hold, 1);
        rot_a = 0;
        en = 1'b0;
        cyc(1);
        chk("s6_dis_hold", a_hold, 0);
        chk("s6_dis_order", a_order, 0);
        chk("s6_dis_rot", rot_a, 0);

        // Shrinking period below the running count fires on the next cycle.
        req = '0; en = 1'b1; period = 8'd5; rot_a = 0;
        cyc(5);
        period = 8'd2;
        cyc(1);
        chk("s7_shrink_rot", rot_a, 1);
        chk("s7_shrink_order", a_order, 1);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            en     = ($urandom_range(0, 15) != 0);
            mode   = 1'($urandom_range(0, 1));
            period = 8'($urandom_range(0, 3));
            req    = 4'($urandom_range(0, 15));
            gnt    = 4'($urandom_range(0, 15));
            clr    = ($urandom_range(0, 59) == 0);
            rst    = ($urandom_range(0, 149) == 0);
            cyc(1);
        end
        chk("rand_nb3_range", bad_b, 0);
        chk("sb_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
